// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and sizing helper for the multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    // Number of CALC cycles needed to retire all operand bits.
    function automatic int unsigned iter_count(input int unsigned data_w, input int unsigned bpc);
        return data_w / bpc;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration: BPC unrolled shift-add multiply or restoring divide steps on magnitudes.
module muldiv_step #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BPC    = 1
) (
    input  logic              div_mode,
    input  logic [DATA_W:0]   hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W:0]   hi_out,
    output logic [DATA_W-1:0] lo_out
);

    logic [DATA_W:0]   h;
    logic [DATA_W-1:0] l;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh;
    logic [DATA_W:0]   diff;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift {h,l} right.
    // Divide: shift {h,l} left, keep the trial subtraction when it does not go negative.
    always_comb begin
        h    = hi_in;
        l    = lo_in;
        sum  = '0;
        sh   = '0;
        diff = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (div_mode) begin
                sh   = {h[DATA_W-1:0], l[DATA_W-1]};
                l    = {l[DATA_W-2:0], 1'b0};
                diff = sh - {1'b0, operand};
                if (!diff[DATA_W]) begin
                    h    = diff;
                    l[0] = 1'b1;
                end else begin
                    h = sh;
                end
            end else begin
                sum = h + (l[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
                l   = {sum[0], l[DATA_W-1:1]};
                h   = {1'b0, sum[DATA_W:1]};
            end
        end
        hi_out = h;
        lo_out = l;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers for the EX stage.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BPC    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              kill_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_zero_o
);

    localparam int unsigned ITERS = iter_count(DATA_W, BPC);
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t state, state_next;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W:0]     acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W:0]     step_hi;
    logic [DATA_W-1:0]   step_lo;
    logic                div_mode;
    logic                neg_res;
    logic                neg_rem;
    logic                zero_div;

    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;
    logic                dz_q;
    logic                busy_q;

    logic                accept_c;
    logic                md_accept_c;
    logic                signed_c;
    logic                is_div_c;
    logic                dz_c;
    logic                neg1_c;
    logic                neg2_c;
    logic [DATA_W-1:0]   mag1_c;
    logic [DATA_W-1:0]   mag2_c;
    logic [2*DATA_W-1:0] prod_c;
    logic [2*DATA_W-1:0] prod_fix_c;
    logic [DATA_W-1:0]   quo_c;
    logic [DATA_W-1:0]   rem_c;

    // Request decode and operand magnitudes for signed ops.
    always_comb begin
        accept_c    = start_i & ~busy_q & ~kill_i & (op_i <= OP_MTLO);
        md_accept_c = accept_c & (op_i <= OP_DIVU);
        signed_c    = (op_i == OP_MULT) | (op_i == OP_DIV);
        is_div_c    = (op_i == OP_DIV) | (op_i == OP_DIVU);
        dz_c        = is_div_c & (src2_i == '0);
        neg1_c      = signed_c & src1_i[DATA_W-1];
        neg2_c      = signed_c & src2_i[DATA_W-1];
        mag1_c      = neg1_c ? -src1_i : src1_i;
        mag2_c      = neg2_c ? -src2_i : src2_i;
    end

    // Sign correction of the magnitude results.
    always_comb begin
        prod_c     = {acc_hi[DATA_W-1:0], acc_lo};
        prod_fix_c = neg_res ? -prod_c : prod_c;
        quo_c      = neg_res ? -acc_lo : acc_lo;
        rem_c      = neg_rem ? -acc_hi[DATA_W-1:0] : acc_hi[DATA_W-1:0];
    end

    muldiv_step #(
        .DATA_W (DATA_W),
        .BPC    (BPC)
    ) u_step (
        .div_mode (div_mode),
        .hi_in    (acc_hi),
        .lo_in    (acc_lo),
        .operand  (operand),
        .hi_out   (step_hi),
        .lo_out   (step_lo)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill returns to IDLE from any busy state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (md_accept_c) begin
                    state_next = dz_c ? FIXUP : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch at accept and iterative accumulator update in CALC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
        end else if (state == IDLE && md_accept_c) begin
            cnt      <= CNT_W'(ITERS - 1);
            acc_hi   <= '0;
            div_mode <= is_div_c;
            zero_div <= dz_c;
            neg_res  <= neg1_c ^ neg2_c;
            neg_rem  <= neg1_c;
            if (is_div_c) begin
                operand <= mag2_c;
                acc_lo  <= dz_c ? src1_i : mag1_c;
            end else begin
                operand <= mag1_c;
                acc_lo  <= mag2_c;
            end
        end else if (state == CALC) begin
            cnt    <= cnt - 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Architectural HI/LO, done pulse, sticky divide-by-zero and busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_next != IDLE);
            if (accept_c) begin
                dz_q <= 1'b0;
                if (op_i == OP_MTHI) begin
                    hi_q <= src1_i;
                end
                if (op_i == OP_MTLO) begin
                    lo_q <= src1_i;
                end
            end
            if (state == FIXUP && !kill_i) begin
                done_q <= 1'b1;
                if (zero_div) begin
                    hi_q <= acc_lo;
                    lo_q <= '1;
                    dz_q <= 1'b1;
                end else if (div_mode) begin
                    hi_q <= rem_c;
                    lo_q <= quo_c;
                end else begin
                    hi_q <= prod_fix_c[2*DATA_W-1:DATA_W];
                    lo_q <= prod_fix_c[DATA_W-1:0];
                end
            end
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign busy_o     = busy_q;
    assign ready_o    = ~busy_q;

endmodule
